word_cell: RTL and testbench

- One addressable storage word of the small SRAM grid: holds WIDTH bits and drives a shared, daisy-chained bit-line bus.
- Each instance sits in a column of word cells. The first cell's `bitLinesIn` is tied to 0; each `bitLinesOut` feeds the next cell's `bitLinesIn`; the last cell's output is the grid's read data.
- Writes capture `word` when the cell's word line is selected in write mode.
- Reads OR the stored word onto the passing bit-line bus; unselected cells are transparent.

---
 rtl/sram_pkg.sv | 9 +
 rtl/bit_cell.sv | 35 +++
 rtl/word_cell.sv | 29 ++
 tb/tb_word_cell.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared constants for the small SRAM grid: default word width and
// the encoding of the grid-wide read/write mode line.
package sram_pkg;

    localparam int   WORD_W   = 8;
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage : sram_pkg

// File: rtl/bit_cell.sv
// One bit of a storage word: a clearable flop written when the word is
// selected in write mode, and a wired-OR tap onto its passing bit line.
module bit_cell
    import sram_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic rw_i,
    input  logic sel_i,
    input  logic d_i,
    input  logic bit_i,
    output logic bit_o
);

    logic mem_q;
    logic mem_d;
    logic wen;
    logic ren;

    assign wen   = (rw_i == RW_WRITE) & sel_i;
    assign ren   = (rw_i == RW_READ) & sel_i;
    assign mem_d = wen ? d_i : mem_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // The unselected path must only see bit_i so a stale mem_q never leaks onto the bus.
    assign bit_o = ren ? (bit_i | mem_q) : bit_i;

endmodule : bit_cell

// File: rtl/word_cell.sv
// One addressable word of the SRAM grid, built from WIDTH bit cells that
// share the mode and word-line selects and each tap one bit line.
module word_cell
    import sram_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rw,
    input  logic             wordLine,
    input  logic [WIDTH-1:0] word,
    input  logic [WIDTH-1:0] bitLinesIn,
    output logic [WIDTH-1:0] bitLinesOut
);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        bit_cell u_bit (
            .clk_i   (clk),
            .rst_n_i (rst_n),
            .rw_i    (rw),
            .sel_i   (wordLine),
            .d_i     (word[b]),
            .bit_i   (bitLinesIn[b]),
            .bit_o   (bitLinesOut[b])
        );
    end

endmodule : word_cell

// File: tb/tb_word_cell.sv
// Directed bench for word_cell: a single cell for the per-cell behaviour
// and an eight-cell column for the daisy-chained read path.
module tb_word_cell;

    logic       clk;
    logic       rst_n;
    logic       rw;
    logic       wordLine;
    logic [7:0] word;
    logic [7:0] bitLinesIn;
    logic [7:0] bitLinesOut;

    logic       chainRw;
    logic [7:0] chainWl;
    logic [7:0] chainWord;
    logic [8:0][7:0] chainBus;

    int checksTotal;
    int checksPassed;

    word_cell #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rw          (rw),
        .wordLine    (wordLine),
        .word        (word),
        .bitLinesIn  (bitLinesIn),
        .bitLinesOut (bitLinesOut)
    );

    assign chainBus[0] = 8'h00;

    for (genvar c = 0; c < 8; c++) begin : g_chain
        word_cell #(.WIDTH(8)) u_cell (
            .clk         (clk),
            .rst_n       (rst_n),
            .rw          (chainRw),
            .wordLine    (chainWl[c]),
            .word        (chainWord),
            .bitLinesIn  (chainBus[c]),
            .bitLinesOut (chainBus[c+1])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checksTotal++;
        assert (observed === expected) begin
            checksPassed++;
        end else begin
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Writes one value into the single cell; inputs change on falling edges.
    task automatic applyStimulus(input logic [7:0] value);
        @(negedge clk);
        rw       = 1'b1;
        wordLine = 1'b1;
        word     = value;
        @(negedge clk);
        rw = 1'b0;
    endtask

    task automatic chainWrite(input int idx, input logic [7:0] value);
        @(negedge clk);
        chainRw   = 1'b1;
        chainWl   = 8'h00;
        chainWl[idx] = 1'b1;
        chainWord = value;
        @(negedge clk);
        chainRw = 1'b0;
        chainWl = 8'h00;
    endtask

    initial begin
        logic [7:0] chainExpect [8];
        checksTotal  = 0;
        checksPassed = 0;
        rst_n      = 1'b0;
        rw         = 1'b0;
        wordLine   = 1'b1;
        word       = 8'h00;
        bitLinesIn = 8'h00;
        chainRw    = 1'b0;
        chainWl    = 8'h00;
        chainWord  = 8'h00;

        #1;
        checkOutput("reset_read", bitLinesOut, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write then read, including the bus during the write cycle.
        @(negedge clk);
        rw = 1'b1; wordLine = 1'b1; word = 8'd42; bitLinesIn = 8'h00;
        #1;
        checkOutput("write_cycle_bus", bitLinesOut, 8'h00);
        @(negedge clk);
        rw = 1'b0;
        #1;
        checkOutput("read_42", bitLinesOut, 8'd42);

        applyStimulus(8'h42);
        bitLinesIn = 8'h81;
        #1;
        checkOutput("or_chain_sel", bitLinesOut, 8'hC3);
        wordLine = 1'b0;
        #1;
        checkOutput("or_chain_unsel", bitLinesOut, 8'h81);
        rw = 1'b1;
        wordLine = 1'b1;
        #1;
        checkOutput("write_mode_passthru", bitLinesOut, 8'h81);
        rw = 1'b0;
        bitLinesIn = 8'h00;

        // Writes must be gated by both the word line and the mode.
        applyStimulus(8'd69);
        @(negedge clk);
        rw = 1'b1; wordLine = 1'b0; word = 8'd127;
        repeat (3) @(negedge clk);
        rw = 1'b0; wordLine = 1'b1;
        #1;
        checkOutput("gate_wordline", bitLinesOut, 8'd69);
        word = 8'd127;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("gate_readmode", bitLinesOut, 8'd69);

        applyStimulus(8'd255);
        #1;
        checkOutput("overwrite_first", bitLinesOut, 8'hFF);
        applyStimulus(8'd69);
        #1;
        checkOutput("overwrite_second", bitLinesOut, 8'd69);

        // Asynchronous clear mid-cycle, away from any clock edge.
        applyStimulus(8'hFF);
        #1;
        checkOutput("pre_async_reset", bitLinesOut, 8'hFF);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", bitLinesOut, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("after_reset_release", bitLinesOut, 8'h00);

        // Reset held across a write edge aborts the write.
        @(negedge clk);
        rst_n = 1'b0;
        rw = 1'b1; wordLine = 1'b1; word = 8'hAA;
        @(negedge clk);
        rw = 1'b0;
        #1;
        checkOutput("abort_write_in_reset", bitLinesOut, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("abort_write_released", bitLinesOut, 8'h00);

        // Mode drops to read just after the capture edge.
        @(negedge clk);
        rw = 1'b1; word = 8'h3C;
        #1;
        checkOutput("capture_write_bus", bitLinesOut, 8'h00);
        @(posedge clk);
        #1;
        rw = 1'b0;
        #1;
        checkOutput("capture_then_read", bitLinesOut, 8'h3C);

        chainWrite(0, 8'd42);
        chainWrite(1, 8'd255);
        chainWrite(3, 8'd69);
        chainWrite(7, 8'd127);
        chainExpect = '{8'd42, 8'd255, 8'd0, 8'd69, 8'd0, 8'd0, 8'd0, 8'd127};
        @(negedge clk);
        chainRw = 1'b0;
        chainWl = 8'h00;
        #1;
        checkOutput("chain_none_selected", chainBus[8], 8'h00);
        for (int i = 0; i < 8; i++) begin
            chainWl = 8'h00;
            chainWl[i] = 1'b1;
            #1;
            checkOutput($sformatf("chain_read_%0d", i), chainBus[8], chainExpect[i]);
        end
        chainRw = 1'b1;
        chainWl = 8'h02;
        chainWord = 8'h00;
        #1;
        checkOutput("chain_write_mode_bus", chainBus[8], 8'h00);
        chainRw = 1'b0;
        chainWl = 8'h00;

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule : tb_word_cell
